// File: rtl/mst_fsm.sv
// Initiator-side control FSM for the register-access request/acknowledge
// interface: one outstanding access, one-cycle request strobe, watchdog abort.
module mst_fsm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  if_req_vld,
  output logic                  if_wr_en,
  output logic                  if_rd_en,
  output logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_wr_data,
  output logic                  if_soft_rst,
  input  logic                  if_ack_vld,
  input  logic [DATA_WIDTH-1:0] if_rd_data,
  input  logic                  if_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ACK = 3'd2,
    ABORT    = 3'd3,
    RSP      = 3'd4
  } state_t;

  // Counter value in the last WAIT_ACK cycle before an abort.
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wd_cnt;
  logic        cap_cmd;
  logic        take_ack;
  logic        go_abort;

  // Control strobes decoded from the state register only.
  assign cmd_rdy     = (state == IDLE);
  assign if_req_vld  = (state == REQ);
  assign if_soft_rst = (state == ABORT);
  assign rsp_vld     = (state == RSP);

  // Next-state selection; acks outside REQ/WAIT_ACK are ignored.
  always_comb begin
    state_nxt = state;
    cap_cmd   = 1'b0;
    take_ack  = 1'b0;
    go_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_vld) begin
          cap_cmd   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (if_ack_vld) begin
          take_ack  = 1'b1;
          state_nxt = RSP;
        end else begin
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (if_ack_vld) begin
          take_ack  = 1'b1;
          state_nxt = RSP;
        end else if (WD_EN && (wd_cnt == WD_LIMIT)) begin
          go_abort  = 1'b1;
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        state_nxt = RSP;
      end
      RSP: begin
        if (rsp_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request/response datapath and saturating watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_addr     <= '0;
      if_wr_data  <= '0;
      if_wr_en    <= 1'b0;
      if_rd_en    <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      if (cap_cmd) begin
        if_addr    <= cmd_addr;
        if_wr_data <= cmd_wdata;
        if_wr_en   <= cmd_wr;
        if_rd_en   <= !cmd_wr;
      end

      if (state == REQ) begin
        wd_cnt <= '0;
      end else if ((state == WAIT_ACK) && (wd_cnt != '1)) begin
        wd_cnt <= wd_cnt + 16'd1;
      end

      if (take_ack) begin
        rsp_err     <= if_err;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= if_rd_en ? if_rd_data : '0;
        if_wr_en    <= 1'b0;
        if_rd_en    <= 1'b0;
      end

      // Abort response is loaded on entry so enables are already low in ABORT.
      if (go_abort) begin
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
        if_wr_en    <= 1'b0;
        if_rd_en    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mst_fsm.sv
// Directed self-checking bench for mst_fsm with an 8-cycle watchdog.
module tb_mst_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        if_req_vld;
  logic        if_wr_en;
  logic        if_rd_en;
  logic [31:0] if_addr;
  logic [31:0] if_wr_data;
  logic        if_soft_rst;
  logic        if_ack_vld;
  logic [31:0] if_rd_data;
  logic        if_err;

  int n_asserts = 0;
  int n_fails   = 0;

  mst_fsm #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .if_req_vld (if_req_vld),
    .if_wr_en   (if_wr_en),
    .if_rd_en   (if_rd_en),
    .if_addr    (if_addr),
    .if_wr_data (if_wr_data),
    .if_soft_rst(if_soft_rst),
    .if_ack_vld (if_ack_vld),
    .if_rd_data (if_rd_data),
    .if_err     (if_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_rdy = 1'b0; if_ack_vld = 1'b0; if_rd_data = '0; if_err = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_req_vld", 32'(if_req_vld), 32'd0);
    chk("rst_en", {30'd0, if_wr_en, if_rd_en}, 32'd0);
    chk("rst_soft_rst", 32'(if_soft_rst), 32'd0);
    chk("rst_addr", if_addr, 32'd0);
    chk("rst_rsp", {30'd0, rsp_err, rsp_timeout}, 32'd0);

    // Write with zero-latency ack (read data on the bus must be ignored)
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001;
    step();
    cmd_vld = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = '0;
    chk("w0_req_vld", 32'(if_req_vld), 32'd1);
    chk("w0_en", {30'd0, if_wr_en, if_rd_en}, 32'd2);
    chk("w0_addr", if_addr, 32'h10);
    chk("w0_wdata", if_wr_data, 32'hA5A5_0001);
    chk("w0_cmd_rdy", 32'(cmd_rdy), 32'd0);
    if_ack_vld = 1'b1; if_err = 1'b0; if_rd_data = 32'h1234_5678;
    step();
    if_ack_vld = 1'b0;
    chk("w0_req_once", 32'(if_req_vld), 32'd0);
    chk("w0_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("w0_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    chk("w0_rsp_rdata", rsp_rdata, 32'd0);
    chk("w0_en_clr", {30'd0, if_wr_en, if_rd_en}, 32'd0);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    chk("w0_idle_rdy", 32'(cmd_rdy), 32'd1);
    chk("w0_idle_rsp", 32'(rsp_vld), 32'd0);

    // Read with ack 5 cycles after the request
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h20;
    step();
    cmd_vld = 1'b0; cmd_addr = 32'h0BAD_0BAD;
    chk("r5_req_vld", 32'(if_req_vld), 32'd1);
    chk("r5_en", {30'd0, if_wr_en, if_rd_en}, 32'd1);
    chk("r5_addr", if_addr, 32'h20);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("r5_hold_req", 32'(if_req_vld), 32'd0);
      chk("r5_hold_en", {30'd0, if_wr_en, if_rd_en}, 32'd1);
      chk("r5_hold_addr", if_addr, 32'h20);
      chk("r5_hold_rsp", 32'(rsp_vld), 32'd0);
    end
    if_ack_vld = 1'b1; if_rd_data = 32'hDEAD_BEEF;
    step();
    if_ack_vld = 1'b0; if_rd_data = '0;
    chk("r5_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("r5_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("r5_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;

    // Error ack on a write, then backpressure with a queued command
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h5555_AAAA;
    step();
    cmd_vld = 1'b0;
    chk("e_req_vld", 32'(if_req_vld), 32'd1);
    step();
    if_ack_vld = 1'b1; if_err = 1'b1;
    step();
    if_ack_vld = 1'b0; if_err = 1'b0;
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
      chk("bp_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd2);
      chk("bp_rsp_rdata", rsp_rdata, 32'd0);
      chk("bp_cmd_rdy", 32'(cmd_rdy), 32'd0);
      chk("bp_req_vld", 32'(if_req_vld), 32'd0);
      step();
    end
    chk("bp_rsp_vld_end", 32'(rsp_vld), 32'd1);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    chk("bp_idle_rdy", 32'(cmd_rdy), 32'd1);
    chk("bp_idle_rsp", 32'(rsp_vld), 32'd0);
    step();
    cmd_vld = 1'b0;
    chk("bp2_req_vld", 32'(if_req_vld), 32'd1);
    chk("bp2_addr", if_addr, 32'h40);
    chk("bp2_en", {30'd0, if_wr_en, if_rd_en}, 32'd1);
    if_ack_vld = 1'b1; if_rd_data = 32'h0BAD_F00D;
    step();
    if_ack_vld = 1'b0; if_rd_data = '0;
    chk("bp2_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("bp2_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;

    // Timeout: request cycle, 8 wait cycles, abort 9 cycles after the request
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h1111_2222;
    step();
    cmd_vld = 1'b0;
    chk("to_req_vld", 32'(if_req_vld), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("to_wait_soft_rst", 32'(if_soft_rst), 32'd0);
      chk("to_wait_en", {30'd0, if_wr_en, if_rd_en}, 32'd2);
    end
    step();
    chk("to_abort_soft_rst", 32'(if_soft_rst), 32'd1);
    chk("to_abort_en", {30'd0, if_wr_en, if_rd_en}, 32'd0);
    chk("to_abort_rsp_vld", 32'(rsp_vld), 32'd0);
    step();
    chk("to_soft_rst_once", 32'(if_soft_rst), 32'd0);
    chk("to_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("to_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd3);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    if_ack_vld = 1'b1; if_rd_data = 32'hFFFF_FFFF; if_err = 1'b0;
    step();
    if_ack_vld = 1'b0; if_rd_data = '0;
    chk("to_late_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("to_late_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd3);
    chk("to_late_rsp_rdata", rsp_rdata, 32'd0);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;

    // Ack in the last wait cycle before the limit beats the watchdog
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h58;
    step();
    cmd_vld = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    chk("lim_no_abort_yet", 32'(if_soft_rst), 32'd0);
    step();
    if_ack_vld = 1'b1; if_rd_data = 32'h600D_CAFE;
    step();
    if_ack_vld = 1'b0; if_rd_data = '0;
    chk("lim_soft_rst", 32'(if_soft_rst), 32'd0);
    chk("lim_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("lim_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    chk("lim_rsp_rdata", rsp_rdata, 32'h600D_CAFE);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;

    // Reset during WAIT_ACK drops the access
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h60;
    step();
    cmd_vld = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("mr_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("mr_req_vld", 32'(if_req_vld), 32'd0);
    chk("mr_en", {30'd0, if_wr_en, if_rd_en}, 32'd0);
    chk("mr_addr", if_addr, 32'd0);
    chk("mr_soft_rst", 32'(if_soft_rst), 32'd0);
    chk("mr_rsp", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    step();
    chk("mr_no_rsp", 32'(rsp_vld), 32'd0);
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'hCAFE_0070;
    step();
    cmd_vld = 1'b0;
    chk("mr2_req_vld", 32'(if_req_vld), 32'd1);
    chk("mr2_addr", if_addr, 32'h70);
    chk("mr2_wdata", if_wr_data, 32'hCAFE_0070);
    if_ack_vld = 1'b1;
    step();
    if_ack_vld = 1'b0;
    chk("mr2_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("mr2_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    chk("mr2_idle", 32'(cmd_rdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
